// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle control sequencer: FSM states,
// recognised opcodes, ALU operation classes and sticky error codes.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
  } state_t;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;

  localparam logic [1:0] ALUOP_R = 2'b10;
  localparam logic [1:0] ALUOP_I = 2'b11;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/multicycle_seq.sv
// Multicycle instruction sequencer: FETCH/DECODE/EXECUTE/WRITEBACK control
// strobes with a bounded fetch wait, sticky error reporting and a retire count.
module multicycle_seq
  import cpu_pkg::*;
#(
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] instr_i,
  output logic        imem_req_o,
  input  logic        imem_ack_i,
  output logic        ir_we_o,
  output logic        alu_src_o,
  output logic [1:0]  alu_op_o,
  output logic        reg_write_o,
  output logic        pc_we_o,
  output logic        busy_o,
  output logic [1:0]  err_o,
  output logic [31:0] retired_o
);

  localparam int unsigned TW = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(FETCH_TIMEOUT - 1);

  state_t      state_reg;
  logic        armed_reg;
  logic [6:0]  opcode_reg;
  logic [TW-1:0] tmo_cnt_reg;
  logic [1:0]  err_reg;
  logic [31:0] retired_reg;
  logic        imem_req_reg;
  logic        busy_reg;
  logic        reg_write_reg;
  logic        pc_we_reg;
  logic        alu_src_reg;
  logic [1:0]  alu_op_reg;

  // Only the opcode field steers sequencing; the rest of the word is the datapath's.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr_i[31:7];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg     <= ST_IDLE;
      armed_reg     <= 1'b0;
      opcode_reg    <= '0;
      tmo_cnt_reg   <= '0;
      err_reg       <= ERR_NONE;
      retired_reg   <= '0;
      imem_req_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      reg_write_reg <= 1'b0;
      pc_we_reg     <= 1'b0;
      alu_src_reg   <= 1'b0;
      alu_op_reg    <= 2'b00;
    end else begin
      // First edge after reset release only arms; FETCH is reachable from the second.
      armed_reg     <= 1'b1;
      reg_write_reg <= 1'b0;
      pc_we_reg     <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start_i && armed_reg) begin
            state_reg    <= ST_FETCH;
            imem_req_reg <= 1'b1;
            busy_reg     <= 1'b1;
            tmo_cnt_reg  <= '0;
          end
        end
        ST_FETCH: begin
          // A late ack on the final allowed cycle still counts as a good fetch.
          if (imem_ack_i) begin
            opcode_reg   <= instr_i[6:0];
            state_reg    <= ST_DECODE;
            imem_req_reg <= 1'b0;
          end else if (tmo_cnt_reg == TMO_LAST) begin
            state_reg    <= ST_HALT;
            imem_req_reg <= 1'b0;
            busy_reg     <= 1'b0;
            err_reg      <= ERR_TIMEOUT;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
        end
        ST_DECODE: begin
          if (opcode_reg == OP_RTYPE) begin
            state_reg   <= ST_EXECUTE;
            alu_src_reg <= 1'b0;
            alu_op_reg  <= ALUOP_R;
          end else if (opcode_reg == OP_ITYPE) begin
            state_reg   <= ST_EXECUTE;
            alu_src_reg <= 1'b1;
            alu_op_reg  <= ALUOP_I;
          end else begin
            state_reg <= ST_HALT;
            busy_reg  <= 1'b0;
            err_reg   <= ERR_ILLEGAL;
          end
        end
        ST_EXECUTE: begin
          state_reg     <= ST_WRITEBACK;
          reg_write_reg <= 1'b1;
          pc_we_reg     <= 1'b1;
        end
        ST_WRITEBACK: begin
          retired_reg <= retired_reg + 32'd1;
          alu_src_reg <= 1'b0;
          alu_op_reg  <= 2'b00;
          if (start_i) begin
            state_reg    <= ST_FETCH;
            imem_req_reg <= 1'b1;
            tmo_cnt_reg  <= '0;
          end else begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end
        end
        ST_HALT: begin
          state_reg <= ST_HALT;
        end
        default: begin
          state_reg    <= ST_IDLE;
          imem_req_reg <= 1'b0;
          busy_reg     <= 1'b0;
          alu_src_reg  <= 1'b0;
          alu_op_reg   <= 2'b00;
        end
      endcase
    end
  end

  // The IR load must coincide with the ack cycle, so it is the one decoded strobe.
  assign ir_we_o     = (state_reg == ST_FETCH) && imem_ack_i;
  assign imem_req_o  = imem_req_reg;
  assign busy_o      = busy_reg;
  assign reg_write_o = reg_write_reg;
  assign pc_we_o     = pc_we_reg;
  assign alu_src_o   = alu_src_reg;
  assign alu_op_o    = alu_op_reg;
  assign err_o       = err_reg;
  assign retired_o   = retired_reg;

endmodule
